instruction_fetch_unit: RTL and testbench

Owns the architectural PC register and drives the instruction-memory port. It consumes the next-PC produced by the execute-stage branch logic as a redirect, and delivers in-order `{pc, instr}` pairs to decode through a valid/ready handshake. A 2-entry fetch buffer lets up to two requests be in flight. Responses belonging to a squashed path are discarded.

---
 rtl/instruction_fetch_unit_pkg.sv | 28 ++
 rtl/instruction_fetch_unit_fetch_buffer.sv | 64 ++++++
 rtl/instruction_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the NOP used to fill fault entries, the default reset PC, the fetch
// FSM state type, the fetch-buffer entry layout and a PC-increment helper.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FB_DEPTH         = 2;

    typedef enum logic {
        FETCH      = 1'b0,
        MISALIGNED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: 32'h0000_0000, instr: 32'h0000_0000, misaligned: 1'b0};

    // Sequential PC step; plain 32-bit addition wraps 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry synchronous FIFO of fetched {pc, instr, misaligned} entries.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i/data_i  : write an entry (ignored when full unless popping)
//   pop_i          : remove the head entry (ignored when empty)
//   flush_i        : discard all entries; wins over push and pop
//   count_o        : current occupancy (0..2)
//   head_o         : oldest entry, meaningful only when count_o != 0
module instruction_fetch_unit_fetch_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push_s;
    logic         do_pop_s;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push_s = push_i & ((count_q != 2'(FB_DEPTH)) | pop_i);
    assign do_pop_s  = pop_i & (count_q != 2'd0);

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= ENTRY_ZERO;
            mem_q[1] <= ENTRY_ZERO;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory requests,
// and hands in-order {pc, instr, misaligned} entries to decode.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   redirect_valid/redirect_pc  : taken branch/jump target from execute
//   imem_req/imem_addr/imem_gnt : request channel (addr = pc_q)
//   imem_rvalid/imem_rdata      : in-order response channel
//   if_valid/if_ready           : decode handshake on the buffer head
//   if_pc/if_instr/if_misaligned: head entry contents
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misaligned
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]   outstanding_q, outstanding_d;
    logic [1:0]   drop_cnt_q, drop_cnt_d;
    logic         fault_pend_q, fault_pend_d;

    logic [1:0]   count_s;
    logic [2:0]   in_use_s;
    logic         grant_s;
    logic         keep_rsp_s;
    logic         redirect_mis_s;
    logic         push_s;
    logic         pop_s;
    fetch_entry_t push_data_s;
    fetch_entry_t head_s;

    // Every in-flight request and every buffered entry reserves a slot, so a
    // response can never land in a full buffer.
    assign in_use_s = {1'b0, outstanding_q} + {1'b0, count_s};
    assign imem_req = ~rst & (state_q == FETCH) & ~redirect_valid
                      & (in_use_s < 3'(BUF_DEPTH));
    assign imem_addr = pc_q;

    assign grant_s        = imem_req & imem_gnt;
    assign keep_rsp_s     = imem_rvalid & (drop_cnt_q == 2'd0) & ~redirect_valid;
    assign redirect_mis_s = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign pop_s          = if_valid & if_ready;

    assign if_valid      = (count_s != 2'd0);
    assign if_pc         = head_s.pc;
    assign if_instr      = head_s.instr;
    assign if_misaligned = head_s.misaligned;

    // Buffer write source: the deferred fault entry or a kept memory response.
    // The two never coincide because a misaligned redirect marks every
    // outstanding response for dropping.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = ENTRY_ZERO;
        if (fault_pend_q & ~redirect_valid) begin
            push_s      = 1'b1;
            push_data_s = '{pc: fetch_pc_q, instr: NOP_INSTR, misaligned: 1'b1};
        end else if (keep_rsp_s) begin
            push_s      = 1'b1;
            push_data_s = '{pc: fetch_pc_q, instr: imem_rdata, misaligned: 1'b0};
        end else begin
            push_s      = 1'b0;
            push_data_s = ENTRY_ZERO;
        end
    end

    // Next-state logic for PC tracking, in-flight bookkeeping and the FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        fault_pend_d  = 1'b0;
        outstanding_d = outstanding_q;

        case ({grant_s, imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            // No grant is possible this cycle, so outstanding_d is exactly the
            // number of old-path responses still to come; any response arriving
            // now is already discarded and excluded from it.
            pc_d         = redirect_pc;
            fetch_pc_d   = redirect_pc;
            drop_cnt_d   = outstanding_d;
            state_d      = redirect_mis_s ? MISALIGNED : FETCH;
            fault_pend_d = redirect_mis_s;
        end else begin
            if (grant_s) begin
                pc_d = pc_inc(pc_q);
            end else begin
                pc_d = pc_q;
            end
            if (keep_rsp_s) begin
                fetch_pc_d = pc_inc(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rvalid && (drop_cnt_q != 2'd0)) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // FSM and fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            fault_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fault_pend_q  <= fault_pend_d;
        end
    end

    instruction_fetch_unit_fetch_buffer u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (redirect_valid),
        .count_o     (count_s),
        .head_o      (head_s)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. A fixed-latency in-order memory
// model answers every granted address with mem_data(addr). A second instance
// with RESET_PC = 32'hFFFF_FFF8 streams against a latency-1 memory to cover
// the PC wrap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2 = 1'b0;
    logic [31:0] imem_rdata2 = 32'h0;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;
    logic        if_misaligned2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    int          mq_due[$];
    logic [31:0] mq_addr[$];
    logic [31:0] grant_addr[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic [31:0] pop_mis[$];
    logic [31:0] pop2_pc[$];
    logic [31:0] pop2_instr[$];
    logic        g2_q = 1'b0;
    logic [31:0] a2_q = 32'h0;
    logic        last_rvalid = 1'b0;
    logic        last_pop = 1'b0;
    int          n_before;

    always #5 clk = ~clk;

    instruction_fetch_unit u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .if_misaligned(if_misaligned)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(1'b1),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .if_valid(if_valid2), .if_ready(1'b1),
        .if_pc(if_pc2), .if_instr(if_instr2), .if_misaligned(if_misaligned2)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: entered at a falling edge with inputs already set,
    // drives memory responses, records grants/pops, returns at the next falling edge.
    task automatic step();
        if (rst) begin
            mq_due.delete();
            mq_addr.delete();
            g2_q = 1'b0;
        end
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(mq_addr[0]);
            void'(mq_due.pop_front());
            void'(mq_addr.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        imem_rvalid2 = g2_q;
        imem_rdata2  = g2_q ? mem_data(a2_q) : 32'h0;
        #1;
        last_rvalid = imem_rvalid;
        last_pop    = if_valid & if_ready;
        if (!rst) begin
            if (imem_req && imem_gnt) begin
                mq_due.push_back(cyc + lat);
                mq_addr.push_back(imem_addr);
                grant_addr.push_back(imem_addr);
            end
            if (if_valid && if_ready) begin
                pop_pc.push_back(if_pc);
                pop_instr.push_back(if_instr);
                pop_mis.push_back({31'b0, if_misaligned});
            end
            if (if_valid2) begin
                pop2_pc.push_back(if_pc2);
                pop2_instr.push_back(if_instr2);
            end
            g2_q = imem_req2;
            a2_q = imem_addr2;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_pops();
        pop_pc.delete();
        pop_instr.delete();
        pop_mis.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        check_val("req_in_rst", {31'b0, imem_req}, 32'h0);
        step();
        rst = 1'b0;
        grant_addr.delete();
        clear_pops();
        pop2_pc.delete();
        pop2_instr.delete();
        #1;
    endtask

    initial begin
        @(negedge clk);

        // Reset state and streaming at latency 1
        lat = 1;
        if_ready = 1'b1;
        do_reset();
        check_val("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check_val("rst_if_pc", if_pc, 32'h0);
        check_val("rst_if_instr", if_instr, 32'h0);
        check_val("rst_if_mis", {31'b0, if_misaligned}, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("req_after_rst", {31'b0, imem_req}, 32'h1);
        check_val("wrap_rst_addr", imem_addr2, 32'hFFFF_FFF8);
        step();
        step();
        check_val("rvalid_lat1", {31'b0, last_rvalid}, 32'h1);
        check_val("ifv_after_rsp", {31'b0, if_valid}, 32'h1);
        check_val("ifpc_after_rsp", if_pc, 32'h0);
        check_val("ifinstr_after_rsp", if_instr, 32'hC0DE_0000);
        repeat (8) step();
        for (int i = 0; i < 3; i++) begin
            check_val("stream_addr", at(grant_addr, i), 32'(4 * i));
            check_val("stream_pc", at(pop_pc, i), 32'(4 * i));
            check_val("stream_instr", at(pop_instr, i), mem_data(32'(4 * i)));
        end
        check_val("wrap_pc0", at(pop2_pc, 0), 32'hFFFF_FFF8);
        check_val("wrap_pc1", at(pop2_pc, 1), 32'hFFFF_FFFC);
        check_val("wrap_pc2", at(pop2_pc, 2), 32'h0000_0000);
        check_val("wrap_instr2", at(pop2_instr, 2), 32'hC0DE_0000);

        // Decode stalled for 10 cycles, then released
        if_ready = 1'b0;
        do_reset();
        repeat (10) step();
        check_val("hold_grants", 32'(grant_addr.size()), 32'd2);
        check_val("hold_req", {31'b0, imem_req}, 32'h0);
        check_val("hold_valid", {31'b0, if_valid}, 32'h1);
        check_val("hold_head", if_pc, 32'h0);
        if_ready = 1'b1;
        repeat (8) step();
        check_val("rel_pc0", at(pop_pc, 0), 32'h0);
        check_val("rel_pc1", at(pop_pc, 1), 32'h4);
        check_val("rel_pc2", at(pop_pc, 2), 32'h8);
        check_val("rel_instr2", at(pop_instr, 2), mem_data(32'h8));

        // Redirect with two requests outstanding at latency 3
        lat = 3;
        if_ready = 1'b1;
        do_reset();
        step();
        step();
        check_val("two_outst_req", {31'b0, imem_req}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        repeat (12) step();
        check_val("redir_grant", at(grant_addr, 2), 32'h100);
        check_val("redir_pc", at(pop_pc, 0), 32'h100);
        check_val("redir_instr", at(pop_instr, 0), mem_data(32'h100));

        // Misaligned redirect holds a fault entry until an aligned redirect
        lat = 1;
        if_ready = 1'b0;
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        n_before = grant_addr.size();
        repeat (6) step();
        check_val("mis_no_grant", 32'(grant_addr.size()), 32'(n_before));
        check_val("mis_req", {31'b0, imem_req}, 32'h0);
        check_val("mis_valid", {31'b0, if_valid}, 32'h1);
        check_val("mis_flag", {31'b0, if_misaligned}, 32'h1);
        check_val("mis_pc", if_pc, 32'h102);
        check_val("mis_instr", if_instr, 32'h13);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        clear_pops();
        repeat (6) step();
        check_val("resume_pc", at(pop_pc, 0), 32'h200);
        check_val("resume_mis", at(pop_mis, 0), 32'h0);

        // Redirect in the same cycle as a response and a decode pop
        lat = 1;
        if_ready = 1'b1;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        check_val("coinc_rvalid", {31'b0, last_rvalid}, 32'h1);
        check_val("coinc_pop", {31'b0, last_pop}, 32'h1);
        check_val("coinc_flush", {31'b0, if_valid}, 32'h0);
        clear_pops();
        repeat (6) step();
        check_val("coinc_next_pc", at(pop_pc, 0), 32'h300);
        check_val("coinc_next_instr", at(pop_instr, 0), mem_data(32'h300));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
